// File: rtl/tlb_ptw.sv
// Two-level page table walker answering TLB PTW requests.
// Issues at most one memory read at a time and returns a single 32-bit PTE (zero on any fault).
module tlb_ptw #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned TO_BITS        = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] vaddr_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] pte_o,
    input  logic [19:0] satp_ppn_i,
    output logic        mem_req_valid_o,
    input  logic        mem_req_ready_i,
    output logic [31:0] mem_addr_o,
    input  logic        mem_resp_valid_i,
    output logic        mem_resp_ready_o,
    input  logic [31:0] mem_rdata_i,
    output logic        busy_o
);

    typedef enum logic [2:0] {
        StIdle,
        StL1Req,
        StL1Wait,
        StL0Req,
        StL0Wait,
        StResp
    } state_e;

    state_e             r_state;
    logic [9:0]         r_vpn0;
    logic [TO_BITS-1:0] r_to_cnt;
    logic [31:0]        r_pte;
    logic [31:0]        r_mem_addr;
    logic               r_mem_req_valid;
    logic               r_resp_valid;

    logic w_pte_v;
    logic w_pte_leaf;
    logic w_misaligned;
    logic w_timeout;
    logic w_unused;

    assign w_pte_v      = mem_rdata_i[0];
    assign w_pte_leaf   = mem_rdata_i[0] & (mem_rdata_i[1] | mem_rdata_i[2]);
    assign w_misaligned = (mem_rdata_i[21:12] != 10'd0);
    assign w_timeout    = (TIMEOUT_CYCLES != 0) &&
                          (r_to_cnt == TO_BITS'(TIMEOUT_CYCLES - 1));
    // Page offset never takes part in the walk.
    assign w_unused     = ^vaddr_i[11:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= StIdle;
            r_vpn0          <= '0;
            r_to_cnt        <= '0;
            r_pte           <= '0;
            r_mem_addr      <= '0;
            r_mem_req_valid <= 1'b0;
            r_resp_valid    <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (req_valid_i) begin
                        r_vpn0          <= vaddr_i[21:12];
                        r_mem_addr      <= {satp_ppn_i, vaddr_i[31:22], 2'b00};
                        r_mem_req_valid <= 1'b1;
                        r_state         <= StL1Req;
                    end
                end
                StL1Req: begin
                    if (mem_req_ready_i) begin
                        r_mem_req_valid <= 1'b0;
                        r_to_cnt        <= '0;
                        r_state         <= StL1Wait;
                    end
                end
                StL1Wait: begin
                    if (mem_resp_valid_i) begin
                        if (!w_pte_v) begin
                            r_pte        <= '0;
                            r_resp_valid <= 1'b1;
                            r_state      <= StResp;
                        end else if (w_pte_leaf) begin
                            // 4 MiB superpage: low VPN bits fill the PPN gap.
                            r_pte        <= w_misaligned ? 32'd0 :
                                            {mem_rdata_i[31:22], r_vpn0, mem_rdata_i[11:0]};
                            r_resp_valid <= 1'b1;
                            r_state      <= StResp;
                        end else begin
                            r_mem_addr      <= {mem_rdata_i[31:12], r_vpn0, 2'b00};
                            r_mem_req_valid <= 1'b1;
                            r_state         <= StL0Req;
                        end
                    end else if (w_timeout) begin
                        r_pte        <= '0;
                        r_resp_valid <= 1'b1;
                        r_state      <= StResp;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                StL0Req: begin
                    if (mem_req_ready_i) begin
                        r_mem_req_valid <= 1'b0;
                        r_to_cnt        <= '0;
                        r_state         <= StL0Wait;
                    end
                end
                StL0Wait: begin
                    if (mem_resp_valid_i) begin
                        r_pte        <= w_pte_leaf ? mem_rdata_i : 32'd0;
                        r_resp_valid <= 1'b1;
                        r_state      <= StResp;
                    end else if (w_timeout) begin
                        r_pte        <= '0;
                        r_resp_valid <= 1'b1;
                        r_state      <= StResp;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                StResp: begin
                    if (resp_ready_i) begin
                        r_resp_valid <= 1'b0;
                        r_state      <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign req_ready_o      = (r_state == StIdle);
    assign busy_o           = (r_state != StIdle);
    // Read data is always drained outside the request states so stale beats cannot stall memory.
    assign mem_resp_ready_o = (r_state != StL1Req) && (r_state != StL0Req);
    assign mem_req_valid_o  = r_mem_req_valid;
    assign mem_addr_o       = r_mem_addr;
    assign resp_valid_o     = r_resp_valid;
    assign pte_o            = r_pte;

endmodule

// File: tb/tb_tlb_ptw.sv
// Scoreboard bench for tlb_ptw: a reactive memory model plus expected-PTE and expected-address queues.
`timescale 1ns/1ps
module tb_tlb_ptw;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [31:0] vaddr_i = '0;
    logic        resp_valid_o;
    logic        resp_ready_i = 1'b1;
    logic [31:0] pte_o;
    logic [19:0] satp_ppn_i = '0;
    logic        mem_req_valid_o;
    logic        mem_req_ready_i = 1'b1;
    logic [31:0] mem_addr_o;
    logic        mem_resp_valid_i = 1'b0;
    logic        mem_resp_ready_o;
    logic [31:0] mem_rdata_i = '0;
    logic        busy_o;

    tlb_ptw #(.TIMEOUT_CYCLES(64), .TO_BITS(7)) u_dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid_i      (req_valid_i),
        .req_ready_o      (req_ready_o),
        .vaddr_i          (vaddr_i),
        .resp_valid_o     (resp_valid_o),
        .resp_ready_i     (resp_ready_i),
        .pte_o            (pte_o),
        .satp_ppn_i       (satp_ppn_i),
        .mem_req_valid_o  (mem_req_valid_o),
        .mem_req_ready_i  (mem_req_ready_i),
        .mem_addr_o       (mem_addr_o),
        .mem_resp_valid_i (mem_resp_valid_i),
        .mem_resp_ready_o (mem_resp_ready_o),
        .mem_rdata_i      (mem_rdata_i),
        .busy_o           (busy_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] mem    [logic [31:0]];
    bit          silent [logic [31:0]];
    logic [31:0] exp_pte_q[$];
    logic [31:0] exp_addr_q[$];

    int n_mem_reads  = 0;
    int n_resp       = 0;
    int n_hold_cyc   = 0;
    int stall_left   = 0;
    int resp_hold    = 0;
    bit inject_late  = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'd0;
    endfunction

    // Memory responder: handshakes are judged at negedge, drives change just after posedge.
    initial begin : mem_model
        bit          req_hs;
        bit          rsp_hs;
        bit          held_v;
        bit          pending;
        logic [31:0] held_addr;
        logic [31:0] pend_data;
        held_v = 1'b0;
        pending = 1'b0;
        held_addr = '0;
        pend_data = '0;
        forever begin
            @(negedge clk);
            req_hs = mem_req_valid_o && mem_req_ready_i;
            rsp_hs = mem_resp_valid_i && mem_resp_ready_o;
            if (mem_req_valid_o && held_v) check("req_addr_stable", mem_addr_o, held_addr);
            held_v    = mem_req_valid_o && !req_hs;
            held_addr = mem_addr_o;
            if (req_hs) begin
                n_mem_reads++;
                if (exp_addr_q.size() != 0) check("mem_addr", mem_addr_o, exp_addr_q.pop_front());
                if (!silent.exists(mem_addr_o)) begin
                    pending   = 1'b1;
                    pend_data = mem_rd(mem_addr_o);
                end
            end
            @(posedge clk);
            #1;
            if (rsp_hs) mem_resp_valid_i = 1'b0;
            if (mem_req_valid_o && stall_left > 0) begin
                mem_req_ready_i = 1'b0;
                stall_left--;
            end else begin
                mem_req_ready_i = 1'b1;
            end
            if (inject_late && !mem_resp_valid_i) begin
                mem_resp_valid_i = 1'b1;
                mem_rdata_i      = 32'hDEADB007;
                inject_late      = 1'b0;
            end else if (pending && !mem_resp_valid_i) begin
                mem_resp_valid_i = 1'b1;
                mem_rdata_i      = pend_data;
                pending          = 1'b0;
            end
        end
    end

    // TLB side: checks every presented PTE against the scoreboard head, applies hold backpressure.
    initial begin : resp_model
        forever begin
            @(negedge clk);
            if (resp_valid_o) begin
                if (exp_pte_q.size() != 0)
                    check(resp_ready_i ? "pte" : "pte_held", pte_o, exp_pte_q[0]);
                if (resp_ready_i) begin
                    n_resp++;
                    if (exp_pte_q.size() != 0) void'(exp_pte_q.pop_front());
                end else begin
                    n_hold_cyc++;
                end
            end
            @(posedge clk);
            #1;
            if (resp_valid_o && resp_hold > 0) begin
                resp_ready_i = 1'b0;
                resp_hold--;
            end else begin
                resp_ready_i = 1'b1;
            end
        end
    end

    task automatic send_req(input logic [31:0] va, input logic [19:0] ppn);
        int k;
        req_valid_i = 1'b1;
        vaddr_i     = va;
        satp_ppn_i  = ppn;
        k = 0;
        @(negedge clk);
        while (!req_ready_o && k < 100) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        vaddr_i     = $urandom;
        satp_ppn_i  = 20'($urandom);
    endtask

    // exp_cyc counts the accept cycle as 1; 0 skips the latency check.
    task automatic do_walk(input string tag, input logic [31:0] exp_pte, input int n_reads,
                           input int exp_cyc);
        int rd0;
        int rsp0;
        int cyc;
        int k;
        rd0  = n_mem_reads;
        rsp0 = n_resp;
        exp_pte_q.push_back(exp_pte);
        send_req(32'h00403123, 20'h00010);
        cyc = 1;
        while (!resp_valid_o && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        if (exp_cyc != 0) check({tag, "_latency"}, cyc, exp_cyc);
        k = 0;
        while (n_resp == rsp0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_resp_count"}, n_resp, rsp0 + 1);
        @(posedge clk);
        #1;
        check({tag, "_resp_drop"}, resp_valid_o, 1'b0);
        check({tag, "_idle_ready"}, req_ready_o, 1'b1);
        check({tag, "_reads"}, n_mem_reads - rd0, n_reads);
        exp_addr_q.delete();
        exp_pte_q.delete();
    endtask

    initial begin : main
        int k;
        int rsp0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pte", pte_o, 32'd0);
        check("rst_addr", mem_addr_o, 32'd0);
        check("rst_resp_valid", resp_valid_o, 1'b0);
        check("rst_mem_req_valid", mem_req_valid_o, 1'b0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_req_ready", req_ready_o, 1'b1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Two-level walk with 3 cycles of TLB backpressure.
        mem[32'h00010004] = 32'h00020001;
        mem[32'h0002000C] = 32'h12345007;
        exp_addr_q = '{32'h00010004, 32'h0002000C};
        n_hold_cyc = 0;
        resp_hold  = 3;
        do_walk("two_level", 32'h12345007, 2, 6);
        check("two_level_hold_cycles", n_hold_cyc, 3);

        mem[32'h00010004] = 32'h1C000003;
        exp_addr_q = '{32'h00010004};
        do_walk("superpage", 32'h1C003003, 1, 4);

        mem[32'h00010004] = 32'h1C001003;
        exp_addr_q = '{32'h00010004};
        do_walk("misaligned", 32'd0, 1, 0);

        mem[32'h00010004] = 32'h00000000;
        exp_addr_q = '{32'h00010004};
        do_walk("l1_invalid", 32'd0, 1, 0);

        mem[32'h00010004] = 32'h00020001;
        mem[32'h0002000C] = 32'h00030001;
        exp_addr_q = '{32'h00010004, 32'h0002000C};
        do_walk("l0_pointer", 32'd0, 2, 0);

        // L1 request backpressure: address must hold, one handshake per level.
        mem[32'h0002000C] = 32'h12345007;
        exp_addr_q = '{32'h00010004, 32'h0002000C};
        stall_left = 5;
        do_walk("stall", 32'h12345007, 2, 11);

        silent[32'h00010004] = 1'b1;
        exp_addr_q = '{32'h00010004};
        do_walk("timeout", 32'd0, 1, 0);
        silent.delete();

        // Late read data landing in IDLE must be swallowed.
        inject_late = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("late_pte_unchanged", pte_o, 32'd0);
        check("late_idle", busy_o, 1'b0);
        exp_addr_q = '{32'h00010004, 32'h0002000C};
        do_walk("after_late", 32'h12345007, 2, 6);

        // Reset while waiting on the L0 read.
        mem[32'h00010004] = 32'h00040001;
        silent[32'h0004000C] = 1'b1;
        exp_addr_q = '{32'h00010004, 32'h0004000C};
        rsp0 = n_resp;
        k = n_mem_reads;
        send_req(32'h00403123, 20'h00010);
        while (n_mem_reads < k + 2 && n_mem_reads < k + 100) @(negedge clk);
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_busy", busy_o, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_rst_busy", busy_o, 1'b0);
        check("mid_rst_req_ready", req_ready_o, 1'b1);
        check("mid_rst_resp_valid", resp_valid_o, 1'b0);
        repeat (80) @(negedge clk);
        check("mid_rst_no_resp", n_resp, rsp0);
        exp_addr_q.delete();
        silent.delete();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
